// File: rtl/sopc_sysid_pkg.sv
// rtl/sopc_sysid_pkg.sv - Shared address map and field constants for sopc_sysid_ext
package sopc_sysid_pkg;

  localparam logic [2:0] ADDR_ID        = 3'd0;
  localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
  localparam logic [2:0] ADDR_SCRATCH   = 3'd2;
  localparam logic [2:0] ADDR_UPTIME_LO = 3'd3;
  localparam logic [2:0] ADDR_UPTIME_HI = 3'd4;
  localparam logic [2:0] ADDR_CTRL      = 3'd5;
  localparam logic [2:0] ADDR_CAPS      = 3'd6;
  localparam logic [2:0] ADDR_RSVD      = 3'd7;

  localparam int unsigned CTRL_ENABLE_BIT = 0;
  localparam int unsigned CTRL_CLEAR_BIT  = 1;

  localparam logic [7:0] CAPS_VERSION = 8'd1;

  // Capability word: divider in the low half, block version above it
  function automatic logic [31:0] caps_word(input logic [15:0] div);
    return {8'h00, CAPS_VERSION, div};
  endfunction

endpackage

// File: rtl/sopc_sysid_uptime.sv
// rtl/sopc_sysid_uptime.sv - Prescaled free-running 64-bit uptime counter
module sopc_sysid_uptime #(
  parameter int unsigned UPTIME_DIV = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        clear,
  output logic [63:0] count
);

  localparam logic [15:0] TERM = 16'(UPTIME_DIV - 1);

  logic [15:0] presc_q, presc_d;
  logic [63:0] count_q, count_d;

  // Next state: clear beats a tick, disabled holds both prescaler and count
  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    if (clear) begin
      presc_d = '0;
      count_d = '0;
    end else if (enable) begin
      if (presc_q == TERM) begin
        presc_d = '0;
        count_d = count_q + 64'd1;
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end
  end

  // Counter state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      count_q <= '0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sopc_sysid_ext.sv
// rtl/sopc_sysid_ext.sv - Avalon-MM system ID slave with scratch and uptime counter
module sopc_sysid_ext
  import sopc_sysid_pkg::*;
#(
  parameter logic [31:0] ID_VALUE     = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
  parameter logic [31:0] SCRATCH_INIT = 32'h0000_0000,
  parameter int unsigned UPTIME_DIV   = 1,
  parameter int unsigned ADDR_W       = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [3:0]        byteenable,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  logic [31:0] scratch_q, scratch_d;
  logic [31:0] hi_snap_q, hi_snap_d;
  logic [31:0] readdata_q, readdata_d;
  logic        rdv_q, rdv_d;
  logic        enable_q, enable_d;

  logic [63:0] uptime;
  logic [31:0] rd_mux;
  logic        wr_scratch, wr_ctrl, rd_lo, clear;

  assign wr_scratch = write && (address == ADDR_SCRATCH);
  assign wr_ctrl    = write && (address == ADDR_CTRL);
  assign rd_lo      = read && (address == ADDR_UPTIME_LO);
  // Clear goes straight to the counter so uptime is zero in the cycle after the write
  assign clear      = wr_ctrl && writedata[CTRL_CLEAR_BIT];

  sopc_sysid_uptime #(
    .UPTIME_DIV(UPTIME_DIV)
  ) u_uptime (
    .clock  (clock),
    .reset_n(reset_n),
    .enable (enable_q),
    .clear  (clear),
    .count  (uptime)
  );

  // Read mux over current (pre-write) register values
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_ID:        rd_mux = ID_VALUE;
      ADDR_TIMESTAMP: rd_mux = TIMESTAMP;
      ADDR_SCRATCH:   rd_mux = scratch_q;
      ADDR_UPTIME_LO: rd_mux = uptime[31:0];
      ADDR_UPTIME_HI: rd_mux = hi_snap_q;
      ADDR_CTRL:      rd_mux[CTRL_ENABLE_BIT] = enable_q;
      ADDR_CAPS:      rd_mux = caps_word(16'(UPTIME_DIV));
      ADDR_RSVD:      rd_mux = '0;
      default:        rd_mux = '0;
    endcase
  end

  // Next state for scratch, control, high-word snapshot and read pipeline
  always_comb begin
    scratch_d = scratch_q;
    for (int k = 0; k < 4; k++) begin
      if (wr_scratch && byteenable[k]) begin
        scratch_d[8*k +: 8] = writedata[8*k +: 8];
      end
    end
    enable_d   = wr_ctrl ? writedata[CTRL_ENABLE_BIT] : enable_q;
    hi_snap_d  = rd_lo ? uptime[63:32] : hi_snap_q;
    rdv_d      = read;
    readdata_d = read ? rd_mux : readdata_q;
  end

  // Register state; reset drops any in-flight response immediately
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch_q  <= SCRATCH_INIT;
      hi_snap_q  <= '0;
      readdata_q <= '0;
      rdv_q      <= 1'b0;
      enable_q   <= 1'b1;
    end else begin
      scratch_q  <= scratch_d;
      hi_snap_q  <= hi_snap_d;
      readdata_q <= readdata_d;
      rdv_q      <= rdv_d;
      enable_q   <= enable_d;
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = rdv_q;

endmodule

// File: tb/tb_sopc_sysid_ext.sv
// tb/tb_sopc_sysid_ext.sv - Scoreboard bench for sopc_sysid_ext (DIV=4 and DIV=1 builds)
module tb_sopc_sysid_ext;

  localparam logic [31:0] ID_V  = 32'h1234ABCD;
  localparam logic [31:0] TS_V  = 32'h5F000000;
  localparam logic [31:0] SCR_A = 32'hA5A50000;

  typedef struct {
    logic [31:0] val;
    string       tag;
  } exp_t;

  logic             clock = 1'b0;
  logic [1:0]       reset_n;
  logic [1:0][2:0]  address;
  logic [1:0]       read;
  logic [1:0]       write;
  logic [1:0][3:0]  byteenable;
  logic [1:0][31:0] writedata;
  logic [1:0][31:0] readdata;
  logic [1:0]       readdatavalid;

  int   total = 0;
  int   bad   = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  exp_t mx;
  int   have;

  logic [63:0] m_cnt [2];
  int          m_pre [2];
  logic        m_en  [2];
  int          m_div [2] = '{4, 1};
  logic [63:0] m_load_val;
  logic        m_load_req = 1'b0;
  logic        m_load_ack = 1'b0;
  logic [63:0] frz;

  always #5 clock = ~clock;

  sopc_sysid_ext #(
    .ID_VALUE(ID_V), .TIMESTAMP(TS_V), .SCRATCH_INIT(SCR_A), .UPTIME_DIV(4), .ADDR_W(3)
  ) dut_a (
    .clock(clock), .reset_n(reset_n[0]), .address(address[0]), .read(read[0]),
    .write(write[0]), .byteenable(byteenable[0]), .writedata(writedata[0]),
    .readdata(readdata[0]), .readdatavalid(readdatavalid[0])
  );

  sopc_sysid_ext #(
    .ID_VALUE(ID_V), .TIMESTAMP(TS_V), .SCRATCH_INIT(32'h0), .UPTIME_DIV(1), .ADDR_W(3)
  ) dut_b (
    .clock(clock), .reset_n(reset_n[1]), .address(address[1]), .read(read[1]),
    .write(write[1]), .byteenable(byteenable[1]), .writedata(writedata[1]),
    .readdata(readdata[1]), .readdatavalid(readdatavalid[1])
  );

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic bus(input int d, input logic rd_en, input logic wr_en, input logic [2:0] a,
                     input logic [31:0] wd, input logic [3:0] be, input logic [31:0] e,
                     input string tag);
    exp_t x;
    read[d] = rd_en; write[d] = wr_en; address[d] = a; writedata[d] = wd; byteenable[d] = be;
    if (rd_en) begin
      x.val = e;
      x.tag = tag;
      if (d == 0) sb0.push_back(x);
      else sb1.push_back(x);
    end
    @(negedge clock);
    read[d] = 1'b0; write[d] = 1'b0; byteenable[d] = 4'h0;
    if (rd_en) expect_eq({tag, "_v"}, readdatavalid[d], 1);
  endtask

  task automatic rd(input int d, input logic [2:0] a, input logic [31:0] e, input string tag);
    bus(d, 1'b1, 1'b0, a, 32'h0, 4'h0, e, tag);
  endtask

  task automatic wr(input int d, input logic [2:0] a, input logic [31:0] wd, input logic [3:0] be);
    bus(d, 1'b0, 1'b1, a, wd, be, 32'h0, "w");
  endtask

  // Reference uptime model, advanced on the same edge as the DUTs
  always @(posedge clock) begin
    if (m_load_req != m_load_ack) begin
      m_cnt[1]   = m_load_val;
      m_load_ack = m_load_req;
    end
    for (int d = 0; d < 2; d++) begin
      if (!reset_n[d]) begin
        m_cnt[d] = 64'd0; m_pre[d] = 0; m_en[d] = 1'b1;
      end else begin
        if (write[d] && address[d] == 3'd5 && writedata[d][1]) begin
          m_cnt[d] = 64'd0; m_pre[d] = 0;
        end else if (m_en[d]) begin
          if (m_pre[d] == m_div[d] - 1) begin
            m_pre[d] = 0; m_cnt[d] = m_cnt[d] + 64'd1;
          end else begin
            m_pre[d] = m_pre[d] + 1;
          end
        end
        if (write[d] && address[d] == 3'd5) m_en[d] = writedata[d][0];
      end
    end
  end

  // Response monitor: every valid beat must match the oldest queued expectation
  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (readdatavalid[d]) begin
        have = 0;
        if (d == 0) begin
          have = sb0.size();
          if (have > 0) mx = sb0.pop_front();
        end else begin
          have = sb1.size();
          if (have > 0) mx = sb1.pop_front();
        end
        if (have == 0) expect_eq("spurious_valid", readdatavalid[d], 0);
        else expect_eq(mx.tag, readdata[d], mx.val);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 2'b00; read = '0; write = '0; address = '0; writedata = '0; byteenable = '0;
    repeat (3) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      expect_eq("rst_rdv", readdatavalid[d], 0);
      expect_eq("rst_rdata", readdata[d], 0);
    end
    reset_n = 2'b11;

    repeat (40) @(negedge clock);
    rd(0, 3'd3, m_cnt[0][31:0], "up40");

    rd(1, 3'd0, ID_V, "id");
    rd(1, 3'd1, TS_V, "ts");
    rd(1, 3'd6, 32'h00010001, "caps_b");
    @(negedge clock);
    expect_eq("valid_gap", readdatavalid[1], 0);
    expect_eq("rd_hold", readdata[1], 32'h00010001);
    rd(0, 3'd6, 32'h00010004, "caps_a");
    rd(0, 3'd5, 32'h1, "ctrl_rst");
    rd(0, 3'd4, 32'h0, "hi_a0");

    rd(0, 3'd2, SCR_A, "scr_init");
    wr(0, 3'd2, 32'hDEADBEEF, 4'b1111);
    wr(0, 3'd2, 32'h00000055, 4'b0001);
    rd(0, 3'd2, 32'hDEADBE55, "scr_be");
    bus(0, 1'b1, 1'b1, 3'd2, 32'h00001100, 4'b0010, 32'hDEADBE55, "rw_old");
    rd(0, 3'd2, 32'hDEAD1155, "rw_new");
    wr(0, 3'd0, 32'hFFFFFFFF, 4'b1111);
    wr(0, 3'd7, 32'hFFFFFFFF, 4'b1111);
    wr(0, 3'd6, 32'hFFFFFFFF, 4'b1111);
    rd(0, 3'd0, ID_V, "id_ro");
    rd(0, 3'd7, 32'h0, "rsvd");
    rd(0, 3'd6, 32'h00010004, "caps_ro");

    wr(0, 3'd5, 32'h0, 4'b1111);
    frz = m_cnt[0];
    repeat (100) @(negedge clock);
    rd(0, 3'd3, frz[31:0], "frz_lo");
    rd(0, 3'd5, 32'h0, "ctrl_off");
    wr(0, 3'd5, 32'h1, 4'b1111);

    m_load_val = 64'h0000_0001_FFFF_FFFF;
    m_load_req = ~m_load_req;
    force dut_b.u_uptime.count_q = 64'h0000_0001_FFFF_FFFF;
    #1;
    release dut_b.u_uptime.count_q;
    rd(1, 3'd3, 32'hFFFFFFFF, "snap_lo");
    rd(1, 3'd4, 32'h1, "snap_hi");
    repeat (5) @(negedge clock);
    rd(1, 3'd4, 32'h1, "snap_hi2");
    rd(1, 3'd3, m_cnt[1][31:0], "wrap_lo");
    rd(1, 3'd4, 32'h2, "wrap_hi");

    wr(1, 3'd5, 32'h3, 4'b1111);
    rd(1, 3'd3, 32'h0, "clr_lo");
    rd(1, 3'd3, 32'h1, "clr_inc");
    rd(1, 3'd4, 32'h0, "clr_hi");
    rd(1, 3'd5, 32'h1, "clr_ctrl");

    read[0] = 1'b1; address[0] = 3'd2;
    @(posedge clock);
    #1;
    read[0] = 1'b0;
    expect_eq("rst_pre_v", readdatavalid[0], 1);
    #1 reset_n[0] = 1'b0;
    #1;
    expect_eq("rst_async_v", readdatavalid[0], 0);
    expect_eq("rst_async_rd", readdata[0], 0);
    @(negedge clock);
    @(negedge clock);
    reset_n[0] = 1'b1;
    rd(0, 3'd2, SCR_A, "rst_scr");
    rd(0, 3'd5, 32'h1, "rst_ctrl");
    rd(0, 3'd4, 32'h0, "rst_hi");
    rd(0, 3'd3, m_cnt[0][31:0], "rst_lo");

    @(negedge clock);
    expect_eq("sb0_empty", sb0.size(), 0);
    expect_eq("sb1_empty", sb1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
